// File: rtl/bram_pkg.sv
// Shared definitions for BRAM-port arbiters: arbiter FSM encoding and a
// ceiling-log2 helper used to size select and counter fields.
package bram_pkg;

  localparam int C_MAX_INTERFACES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Smallest width able to index `value` distinct items (minimum 1).
  function automatic int clogb2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set req bit scanning last+1, last+2, ...
// with wrap-around, so the previous winner has the lowest priority.
module rr_priority_pick #(
  parameter int N        = 2,
  parameter int SEL_BITS = 1
) (
  input  logic [N-1:0]        req,
  input  logic [SEL_BITS-1:0] last,
  output logic [SEL_BITS-1:0] winner,
  output logic                valid
);

  localparam int IW = SEL_BITS + 1;

  always_comb begin
    logic [IW-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      // last + i never exceeds 2N-1, so one conditional subtract wraps it
      idx = {1'b0, last} + IW'(i);
      if (idx >= IW'(N)) idx = idx - IW'(N);
      if (!valid && req[idx[SEL_BITS-1:0]]) begin
        valid  = 1'b1;
        winner = idx[SEL_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin owner of one shared BRAM port: burst grants with bounded tenure,
// and a read-latency drain on every hand-over before the mux select may move.
module bram_rr_arbiter
  import bram_pkg::*;
#(
  parameter int C_NUM_INTERFACES = 2,
  parameter int C_READ_LATENCY   = 1,
  parameter int C_MAX_HOLD       = 16,
  localparam int SEL_BITS        = clogb2(C_NUM_INTERFACES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [C_NUM_INTERFACES-1:0] req,
  output logic [C_NUM_INTERFACES-1:0] gnt,
  output logic [SEL_BITS-1:0]         sel,
  output logic                        busy,
  output logic                        preempt,
  output arb_state_t                  dbg_state
);

  localparam int N          = C_NUM_INTERFACES;
  localparam int HOLD_BITS  = clogb2(C_MAX_HOLD + 1);
  localparam int DRAIN_BITS = clogb2(C_READ_LATENCY + 1);
  localparam logic [HOLD_BITS-1:0]  HOLD_MAX  = HOLD_BITS'(C_MAX_HOLD);
  localparam logic [DRAIN_BITS-1:0] DRAIN_LEN = DRAIN_BITS'(C_READ_LATENCY);

  if (N < 2 || N > C_MAX_INTERFACES) begin : g_bad_num
    $error("C_NUM_INTERFACES out of range");
  end
  if (C_READ_LATENCY < 1 || C_READ_LATENCY > 3) begin : g_bad_lat
    $error("C_READ_LATENCY out of range");
  end
  if (C_MAX_HOLD < 2) begin : g_bad_hold
    $error("C_MAX_HOLD must be at least 2");
  end

  arb_state_t state, state_n;
  logic [N-1:0]          gnt_n;
  logic [SEL_BITS-1:0]   sel_n, last, last_n;
  logic [HOLD_BITS-1:0]  hold_cnt, hold_n;
  logic [DRAIN_BITS-1:0] drain_cnt, drain_n;
  logic                  preempt_n;

  logic [SEL_BITS-1:0] pick_winner;
  logic                pick_valid;
  logic                owner_req;
  logic                others_req;
  logic                expire;

  rr_priority_pick #(
    .N        (N),
    .SEL_BITS (SEL_BITS)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // In GRANT, sel names the owner and gnt is its one-hot, so masking with gnt
  // leaves exactly the competing requesters.
  assign owner_req  = req[sel];
  assign others_req = |(req & ~gnt);
  assign expire     = (hold_cnt == HOLD_MAX) && others_req;

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    sel_n     = sel;
    last_n    = last;
    hold_n    = hold_cnt;
    drain_n   = drain_cnt;
    preempt_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_n              = '0;
          gnt_n[pick_winner] = 1'b1;
          sel_n              = pick_winner;
          last_n             = pick_winner;
          hold_n             = HOLD_BITS'(1);
          state_n            = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req || expire) begin
          gnt_n     = '0;
          drain_n   = DRAIN_LEN;
          preempt_n = expire;
          state_n   = ST_DRAIN;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + HOLD_BITS'(1);
        end
      end
      ST_DRAIN: begin
        // sel stays on the old owner so its in-flight read data still routes back
        drain_n = drain_cnt - DRAIN_BITS'(1);
        if (drain_cnt == DRAIN_BITS'(1)) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      sel       <= '0;
      last      <= SEL_BITS'(N - 1);
      hold_cnt  <= '0;
      drain_cnt <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      sel       <= sel_n;
      last      <= last_n;
      hold_cnt  <= hold_n;
      drain_cnt <= drain_n;
      preempt   <= preempt_n;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: directed bursts plus random requests, scored
// against a tenure-level reference model through an expected-response queue.
module tb_bram_rr_arbiter;
  import bram_pkg::*;

  localparam int N      = 4;
  localparam int LAT    = 2;
  localparam int MAXH   = 6;
  localparam int SB     = 2;
  localparam int STARVE = N * (MAXH + LAT + 2);

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [SB-1:0] sel;
  logic          busy;
  logic          preempt;
  arb_state_t    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_rr_arbiter #(
    .C_NUM_INTERFACES (N),
    .C_READ_LATENCY   (LAT),
    .C_MAX_HOLD       (MAXH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .preempt   (preempt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [SB-1:0] sel;
    logic          busy;
    logic          preempt;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tenure view: an owner (or -1), how long it has held, drain cycles left.
  int m_owner, m_held, m_drain, m_last, m_sel;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_drain = 0;
    m_last  = N - 1;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    exp_t e;
    int   g;
    bit   pre;
    bit   found;
    bit   others;
    pre = 1'b0;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1'b1;
      if (m_held == MAXH && others) begin
        pre     = 1'b1;
        m_owner = -1;
        m_drain = LAT;
      end else if (!r[m_owner]) begin
        m_owner = -1;
        m_drain = LAT;
      end else if (m_held < MAXH) begin
        m_held++;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && r[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_last  = c;
          m_sel   = c;
          m_held  = 1;
        end
      end
    end
    g         = (m_owner >= 0) ? (1 << m_owner) : 0;
    e.gnt     = g[N-1:0];
    e.sel     = SB'(m_sel);
    e.busy    = (m_owner >= 0) || (m_drain > 0);
    e.preempt = pre;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] v);
    req = v;
    model_step(v);
  endtask

  task automatic cycle(input logic [N-1:0] v);
    @(negedge clk);
    drive(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, int'(gnt), 0);
    check({tag, "_sel"}, int'(sel), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_preempt"}, int'(preempt), 0);
  endtask

  // ---------------- monitor ----------------
  int            wait_c[N];
  logic [N-1:0]  prev_gnt;
  logic [SB-1:0] prev_sel;

  always @(posedge clk) begin
    exp_t e;
    int   worst;
    #1;
    if (rst) begin
      for (int i = 0; i < N; i++) wait_c[i] = 0;
      prev_gnt = '0;
      prev_sel = '0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", int'(gnt), int'(e.gnt));
        check("sel", int'(sel), int'(e.sel));
        check("busy", int'(busy), int'(e.busy));
        check("preempt", int'(preempt), int'(e.preempt));
      end
      check("onehot0", int'($onehot0(gnt)), 1);
      if (dbg_state == ST_DRAIN) check("drain_gnt", int'(gnt), 0);
      if (prev_gnt != '0 && gnt != '0) check("sel_stable", int'(sel), int'(prev_sel));
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > worst) worst = wait_c[i];
      end
      check("starve", int'(worst > STARVE), 0);
      prev_gnt = gnt;
      prev_sel = sel;
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] rand_req;

  initial begin
    req      = '0;
    rand_req = '0;
    rst      = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");

    // single requester, then release
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0001);
    repeat (2) cycle(4'b0001);
    repeat (4) cycle(4'b0000);

    // everyone requesting: rotation with tenure expiry
    repeat (4 * (MAXH + LAT + 2) + 4) cycle(4'b1111);
    repeat (6) cycle(4'b0000);

    // lone owner past the hold limit, then a newcomer preempts
    repeat (3 * MAXH) cycle(4'b0100);
    repeat (MAXH + LAT + 6) cycle(4'b0101);
    repeat (6) cycle(4'b0000);

    // one-cycle request pulse
    cycle(4'b0010);
    repeat (6) cycle(4'b0000);

    // owner releases in the same cycle another requester arrives
    repeat (3) cycle(4'b0010);
    repeat (LAT + 4) cycle(4'b1000);
    repeat (4) cycle(4'b0000);

    // asynchronous reset in the middle of a tenure
    repeat (3) cycle(4'b0100);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1 check_reset_outputs("mid_rst");
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(4'b0101);
    repeat (4) cycle(4'b0101);
    repeat (MAXH + LAT + 4) cycle(4'b0000);

    // random requests with some persistence between changes
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rand_req = N'($urandom_range(0, (1 << N) - 1));
      cycle(rand_req);
    end
    repeat (MAXH + LAT + 4) cycle(4'b0000);

    @(posedge clk);
    #2 check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
